unsigned_approx_mult_pipe: RTL and testbench

//  Parametrised, pipelined unsigned WxW multiplier with a per-transaction exact/approximate mode.

---
 rtl/mult_pkg.sv | 15 +
 rtl/pp_column_sum.sv | 29 ++
 rtl/unsigned_approx_mult_pipe.sv | 157 +++++++++++++++
 tb/tb_unsigned_approx_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined approximate multiplier.
package mult_pkg;

  // Width of one partial-product column count (a column holds at most w bits).
  function automatic int col_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Bias added to approximate products to re-centre the truncation error.
  function automatic logic [31:0] approx_bias(input int l);
    if (l > 0) return 32'd1 << (l - 1);
    return 32'd0;
  endfunction

endpackage

// File: rtl/pp_column_sum.sv
// Combinational partial-product column reducer; in approximate mode the
// columns below L are masked out.
module pp_column_sum
  import mult_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 6,
  localparam int NCOL = 2 * W - 1,
  localparam int CW = col_cnt_w(W)
) (
  input  logic [W-1:0]             x,
  input  logic [W-1:0]             y,
  input  logic                     approx,
  output logic [NCOL-1:0][CW-1:0]  cols
);

  // Count the set partial-product bits landing in each column.
  always_comb begin
    cols = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (!approx || (i + j) >= L) begin
          cols[i+j] = cols[i+j] + CW'(x[i] & y[j]);
        end
      end
    end
  end

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// Pipelined unsigned WxW multiplier with per-beat exact/approximate mode,
// valid/ready flow control, tag passthrough and a saturating approx counter.
// Stage 0 holds column counts; the last stage holds the summed product
// (with STAGES=1 the product is summed straight from stage 0).
module unsigned_approx_mult_pipe
  import mult_pkg::*;
#(
  parameter int W      = 8,
  parameter int L      = 6,
  parameter int STAGES = 2,
  parameter int TAGW   = 4,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic              approx,
  input  logic [TAGW-1:0]   tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    z,
  output logic [TAGW-1:0]   tag_out,
  output logic              approx_out,
  output logic [CNTW-1:0]   approx_cnt,
  input  logic              cnt_clr
);

  localparam int NCOL = 2 * W - 1;
  localparam int CW   = col_cnt_w(W);
  localparam int PW   = 2 * W;
  localparam int NCS  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [PW-1:0] BIAS = PW'(approx_bias(L));

  typedef struct packed {
    logic [NCOL-1:0][CW-1:0] cols;
    logic                    bias;
    logic [TAGW-1:0]         tag;
    logic                    approx;
  } cnt_stage_t;

  typedef struct packed {
    logic [PW-1:0]   prod;
    logic [TAGW-1:0] tag;
    logic            approx;
  } res_stage_t;

  logic [STAGES-1:0]       vld_q, vld_d, adv;
  cnt_stage_t              cnt_q [NCS];
  cnt_stage_t              cnt_d [NCS];
  logic [NCOL-1:0][CW-1:0] cols_in;
  logic [CNTW-1:0]         approx_cnt_q, approx_cnt_d;
  logic [PW-1:0]           sum_prod;
  logic                    in_fire;

  pp_column_sum #(.W(W), .L(L)) u_pp (
    .x      (x),
    .y      (y),
    .approx (approx),
    .cols   (cols_in)
  );

  // A stage advances if it, or any stage after it, is empty, or the output drains.
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = out_ready;
      for (int k = s; k < STAGES; k++) begin
        if (!vld_q[k]) adv[s] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];
  assign in_fire  = in_valid && in_ready;

  // Next valid bits and count-stage payloads; payloads only move with a valid beat.
  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (adv[0]) vld_d[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) vld_d[s] = vld_q[s-1];
    end
    if (in_fire) begin
      cnt_d[0] = '{cols:   cols_in,
                   bias:   approx && (L > 0) && (x != '0) && (y != '0),
                   tag:    tag_in,
                   approx: approx};
    end
    for (int s = 1; s < NCS; s++) begin
      if (adv[s] && vld_q[s-1]) cnt_d[s] = cnt_q[s-1];
    end
  end

  // Weighted sum of the last count stage plus the optional bias, modulo 2^2W.
  always_comb begin
    sum_prod = BIAS & {PW{cnt_q[NCS-1].bias}};
    for (int c = 0; c < NCOL; c++) begin
      sum_prod = sum_prod + (PW'(cnt_q[NCS-1].cols[c]) << c);
    end
  end

  // Saturating approx-beat counter; clear beats a simultaneous increment.
  always_comb begin
    approx_cnt_d = approx_cnt_q;
    if (cnt_clr) approx_cnt_d = '0;
    else if (in_fire && approx && approx_cnt_q != '1) approx_cnt_d = approx_cnt_q + CNTW'(1);
  end

  // Valid chain, count stages and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      approx_cnt_q <= '0;
      for (int s = 0; s < NCS; s++) cnt_q[s] <= '0;
    end else begin
      vld_q        <= vld_d;
      approx_cnt_q <= approx_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  generate
    if (STAGES > 1) begin : g_res
      res_stage_t res_q, res_d;

      // Final stage captures the summed product when the last count stage hands over.
      always_comb begin
        res_d = res_q;
        if (adv[STAGES-1] && vld_q[STAGES-2]) begin
          res_d = '{prod: sum_prod, tag: cnt_q[NCS-1].tag, approx: cnt_q[NCS-1].approx};
        end
      end

      // Result register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
      end

      assign z          = res_q.prod;
      assign tag_out    = res_q.tag;
      assign approx_out = res_q.approx;
    end else begin : g_nores
      assign z          = sum_prod;
      assign tag_out    = cnt_q[0].tag;
      assign approx_out = cnt_q[0].approx;
    end
  endgenerate

  assign out_valid  = vld_q[STAGES-1];
  assign approx_cnt = approx_cnt_q;

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Bench for unsigned_approx_mult_pipe: three instances sharing stimulus
// (W=8 L=6 S=2 CNTW=16; W=8 L=6 S=1 CNTW=4; W=8 L=0 S=3 CNTW=16),
// each tracked by its own scoreboard against an arithmetic reference.
module tb_unsigned_approx_mult_pipe;

  localparam int ND = 3;
  localparam int S_[ND] = '{2, 1, 3};
  localparam int L_[ND] = '{6, 6, 0};

  typedef struct packed {
    logic [15:0] z;
    logic [3:0]  tag;
    logic        ap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, approx, out_ready, cnt_clr;
  logic [7:0]  x, y;
  logic [3:0]  tag_in;
  logic        in_rdy [ND];
  logic        o_valid [ND];
  logic        o_ap [ND];
  logic [15:0] o_z [ND];
  logic [3:0]  o_tag [ND];
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t sb [ND][64];
  int   wp [ND];
  int   rp [ND];
  bit   hold [ND];
  exp_t hv [ND];
  int   first_in [ND];
  int   first_out [ND];
  bit   lat_arm;

  always #5 clk = ~clk;

  unsigned_approx_mult_pipe #(.W(8), .L(6), .STAGES(2), .TAGW(4), .CNTW(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .x(x), .y(y),
    .approx(approx), .tag_in(tag_in), .out_valid(o_valid[0]), .out_ready(out_ready),
    .z(o_z[0]), .tag_out(o_tag[0]), .approx_out(o_ap[0]), .approx_cnt(cnt0), .cnt_clr(cnt_clr));

  unsigned_approx_mult_pipe #(.W(8), .L(6), .STAGES(1), .TAGW(4), .CNTW(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .x(x), .y(y),
    .approx(approx), .tag_in(tag_in), .out_valid(o_valid[1]), .out_ready(out_ready),
    .z(o_z[1]), .tag_out(o_tag[1]), .approx_out(o_ap[1]), .approx_cnt(cnt1), .cnt_clr(cnt_clr));

  unsigned_approx_mult_pipe #(.W(8), .L(0), .STAGES(3), .TAGW(4), .CNTW(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .x(x), .y(y),
    .approx(approx), .tag_in(tag_in), .out_valid(o_valid[2]), .out_ready(out_ready),
    .z(o_z[2]), .tag_out(o_tag[2]), .approx_out(o_ap[2]), .approx_cnt(cnt2), .cnt_clr(cnt_clr));

  // Reference: each set bit of x contributes y with the bits that would land below column l cleared.
  function automatic logic [15:0] ref_prod(logic [7:0] xv, logic [7:0] yv, logic ap, int l);
    int acc;
    int sh;
    if (!ap) return 16'(int'(xv) * int'(yv));
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (xv[i]) begin
        sh = (l > i) ? l - i : 0;
        acc += ((int'(yv) >> sh) << sh) << i;
      end
    end
    if (l > 0 && xv != 0 && yv != 0) acc += 1 << (l - 1);
    return 16'(acc);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: settle, score handshakes of every instance, then advance past the edge.
  task automatic tick();
    int   occ;
    exp_t e;
    #2;
    for (int d = 0; d < ND; d++) begin
      occ = wp[d] - rp[d];
      check($sformatf("d%0d_in_ready", d), in_rdy[d], !(occ == S_[d] && !out_ready));
      if (hold[d]) begin
        check($sformatf("d%0d_hold_valid", d), o_valid[d], 1);
        check($sformatf("d%0d_hold_z", d), o_z[d], hv[d].z);
        check($sformatf("d%0d_hold_tag", d), o_tag[d], hv[d].tag);
        check($sformatf("d%0d_hold_ap", d), o_ap[d], hv[d].ap);
      end
      hold[d] = o_valid[d] && !out_ready;
      hv[d]   = '{z: o_z[d], tag: o_tag[d], ap: o_ap[d]};
      if (lat_arm) begin
        if (in_valid && in_rdy[d] && first_in[d] < 0) first_in[d] = cyc;
        if (o_valid[d] && first_out[d] < 0) first_out[d] = cyc;
      end
      if (in_valid && in_rdy[d]) begin
        sb[d][wp[d] % 64] = '{z: ref_prod(x, y, approx, L_[d]), tag: tag_in, ap: approx};
        wp[d]++;
      end
      if (o_valid[d] && out_ready) begin
        check($sformatf("d%0d_beat_expected", d), (occ > 0), 1);
        if (occ > 0) begin
          e = sb[d][rp[d] % 64];
          rp[d]++;
          check($sformatf("d%0d_z", d), o_z[d], e.z);
          check($sformatf("d%0d_tag", d), o_tag[d], e.tag);
          check($sformatf("d%0d_ap", d), o_ap[d], e.ap);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_rst_valid", d), o_valid[d], 0);
      check($sformatf("d%0d_rst_in_ready", d), in_rdy[d], 1);
      check($sformatf("d%0d_rst_z", d), o_z[d], 0);
      check($sformatf("d%0d_rst_tag", d), o_tag[d], 0);
      check($sformatf("d%0d_rst_ap", d), o_ap[d], 0);
      wp[d] = 0;
      rp[d] = 0;
      hold[d] = 1'b0;
      first_in[d] = -1;
      first_out[d] = -1;
    end
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_cnt2", cnt2, 0);
    lat_arm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bool_loop: for (int k = 0; k < 30; k++) begin
      if (wp[0] == rp[0] && wp[1] == rp[1] && wp[2] == rp[2]) break;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
    end
    for (int d = 0; d < ND; d++) check($sformatf("d%0d_drained", d), wp[d] - rp[d], 0);
  endtask

  task automatic send(logic [7:0] xv, logic [7:0] yv, logic ap, logic [3:0] tg);
    x = xv;
    y = yv;
    approx = ap;
    tag_in = tg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic directed(string tag, logic [7:0] xv, logic [7:0] yv, logic ap, logic [15:0] expz);
    drain();
    send(xv, yv, ap, 4'hA);
    for (int k = 0; k < 10; k++) begin
      if (o_valid[0]) break;
      tick();
    end
    check({tag, "_valid"}, o_valid[0], 1);
    check({tag, "_z"}, o_z[0], expz);
    tick();
  endtask

  task automatic check_latency();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_latency", d), first_out[d] - first_in[d], S_[d]);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    approx = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    x = '0;
    y = '0;
    tag_in = '0;
    do_reset();

    // Directed products at L=6 (instance 0).
    directed("t1_exact_255", 8'd255, 8'd255, 1'b0, 16'd65025);
    directed("t1_approx_255", 8'd255, 8'd255, 1'b1, 16'd64736);
    directed("t2_zero_nobias", 8'd0, 8'd255, 1'b1, 16'd0);
    directed("t2_approx_3x3", 8'd3, 8'd3, 1'b1, 16'd32);
    directed("t2_exact_3x3", 8'd3, 8'd3, 1'b0, 16'd9);
    drain();

    // Back-to-back random stream, latency from the first accepted beat.
    do_reset();
    lat_arm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      approx = 1'($urandom);
      tag_in = 4'(i);
      in_valid = 1'b1;
      tick();
    end
    drain();
    check_latency();

    // Random backpressure.
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom);
      in_valid = ($urandom_range(3) != 0);
      x = 8'($urandom);
      y = 8'($urandom);
      approx = 1'($urandom);
      tag_in = 4'($urandom);
      tick();
    end
    drain();

    // Reset with two beats in flight.
    do_reset();
    send(8'd17, 8'd200, 1'b1, 4'h1);
    send(8'd99, 8'd45, 1'b1, 4'h2);
    check("t5_cnt_before", cnt0, 2);
    check("t5_valid_before", o_valid[0], 1);
    do_reset();
    lat_arm = 1'b1;
    send(8'd123, 8'd77, 1'b1, 4'h3);
    drain();
    check_latency();

    // Counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < 17; i++) send(8'($urandom), 8'($urandom), 1'b1, 4'(i));
    check("t6_cnt4_sat", cnt1, 15);
    check("t6_cnt16", cnt0, 17);
    send(8'd5, 8'd6, 1'b0, 4'h0);
    check("t6_cnt4_exact_noinc", cnt1, 15);
    check("t6_cnt16_exact_noinc", cnt0, 17);
    cnt_clr = 1'b1;
    send(8'd5, 8'd6, 1'b1, 4'h0);
    cnt_clr = 1'b0;
    check("t6_clr_cnt4", cnt1, 0);
    check("t6_clr_cnt16", cnt0, 0);
    send(8'd7, 8'd9, 1'b1, 4'h0);
    check("t6_after_clr_cnt4", cnt1, 1);
    drain();

    // Long random run: the L=0 instance must produce exact products in approx mode.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      approx = 1'b1;
      tag_in = 4'($urandom);
      in_valid = 1'b1;
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
